rwave_fifo_ctrl: RTL and testbench
==================================

// Module: rwave_fifo_ctrl
// PURPOSE
//  Sequencer for the R-wave dual sample FIFO (A/B, DEPTH words each).
//  Runs a fill phase: 8-sample blocks written on alternate cycles.
//  Then runs a drain phase: FIFO A is shifted for consumer A, and FIFO B for consumer B in parallel mode.
//  Sits between the sample packer upstream and the R-peak search engines downstream.
// PARAMETERS
//  DEPTH  800  words per FIFO; must be a multiple of LANES
//  LANES  8    samples per write block
//  PTR_W  10   width of pointers/counters; 2**PTR_W > DEPTH
// PORTS
//  clk        in   1      rising-edge clock
//  Reset      in   1      asynchronous, active-high reset
//  Enable     in   1      0 = synchronous abort to IDLE
//  start      in   1      pulse; begins a fill, ignored unless IDLE
//  mode_par   in   1      sampled on start: 1 = parallel (A+B), 0 = serial (A only)
//  blk_valid  in   1      upstream 8-sample block available
//  blk_ready  out  1      block accepted at edge when blk_valid&blk_ready
//  wr_en      out  1      write strobe to FIFO A and B, one cycle
//  wr_ptr     out  PTR_W  base address of the block written under wr_en
//  req_a      in   1      consumer A requests next tap
//  req_b      in   1      consumer B requests next tap
//  shift_a    out  1      shift FIFO A by one word
//  shift_b    out  1      shift FIFO B by one word
//  rd_cnt_a   out  PTR_W  taps delivered from A
//  rd_cnt_b   out  PTR_W  taps delivered from B
//  busy       out  1      state != IDLE
//  done       out  1      one-cycle pulse on drain completion
//  err        out  1      sticky protocol error (see CONFIGURATION)
// BEHAVIOUR
//  - All outputs registered; Reset drives every output to 0, state to IDLE, and ptr, toggle and counters to 0.
//  - FSM states are IDLE, FILL, DRAIN and DONE.
//  - IDLE: start=1 latches mode_par, clears ptr, toggle and rd_cnt_*, then goes to FILL.
//  - FILL: blk_ready=~toggle.
//    - Accepting a block at edge N gives wr_en=1 and wr_ptr=ptr in cycle N+1, then ptr+=LANES and toggle=1.
//    - At the next edge toggle returns to 0, so at most one block is accepted per 2 cycles.
//    - While blk_valid=0, blk_ready holds at 1.
//    - Accepting the block at ptr=DEPTH-LANES moves the FSM to DRAIN; blk_ready=0 from then on.
//  - DRAIN: req_a is accepted iff rd_cnt_a<DEPTH.
//    - Acceptance at edge N gives shift_a=1 in cycle N+1 and rd_cnt_a+1.
//    - req_b is handled the same way, but only in parallel mode; in serial mode req_b is ignored.
//    - A and B may be accepted at the same edge and run independently.
//    - Completion: rd_cnt_a==DEPTH (serial) or both counts ==DEPTH (parallel) moves the FSM to DONE.
//  - DONE: done=1 for one cycle, then IDLE; the counts hold until the next start.
//  - Enable=0 in any state: next edge goes to IDLE and clears ptr and toggle; wr_en/shift_* are 0 and done is not pulsed.
//  - Reset mid-fill or mid-drain: immediate return to IDLE.
//  - No partial-block write, and the counters never exceed DEPTH.
//  - start while busy is ignored.
//  - The counters saturate, so no wrap-around is possible.
// CONFIGURATION
//  RWAVE_CTRL_ERR_EN defined:
//   - err is set by any of:
//     - req_a or req_b in FILL
//     - req_x with rd_cnt_x==DEPTH in DRAIN
//     - req_b in serial mode during DRAIN
//   - err is cleared only by Reset or an accepted start.
//  RWAVE_CTRL_ERR_EN undefined: err is tied 0 and no error logic is built; all other behaviour is identical.
// TESTING
//  - Reset check: Reset=1 during FILL with ptr=96 -> all outputs 0, busy=0 in the same cycle.
//  - Fill cadence: start, blk_valid held 1 -> wr_en on alternate cycles, wr_ptr 0,8,..,792.
//    100 writes in 200 cycles, then DRAIN with blk_ready=0.
//  - Serial drain: mode_par=0, req_a and req_b held 1 -> 800 shift_a pulses, shift_b never asserted.
//    rd_cnt_a=800, rd_cnt_b=0, done pulse once.
//  - Parallel drain: mode_par=1, req_a always, req_b every 3rd cycle -> done only after rd_cnt_b=800.
//    rd_cnt_a stays at 800 and shift_a=0 after saturation.
//  - Abort: Enable=0 for 1 cycle at wr_ptr=400 -> IDLE, no done.
//    A new start refills from wr_ptr=0.
//  - Error flag: with RWAVE_CTRL_ERR_EN, req_a during FILL -> err=1 that persists through DONE.
//    The next start clears it. Without the macro, err stays 0.

Source files
------------

// File: rtl/rwave_fifo_ctrl.sv
// Fill/drain sequencer for the R-wave dual sample FIFO (A/B, DEPTH words each).
// Latency: every output is registered, one cycle after the accepting edge. Backpressure: blk_ready, at most one block per 2 cycles.
// Optional sticky protocol-error flag built only when RWAVE_CTRL_ERR_EN is defined.
module rwave_fifo_ctrl #(
    parameter int DEPTH = 800,
    parameter int LANES = 8,
    parameter int PTR_W = 10
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             start,
    input  logic             mode_par,
    input  logic             blk_valid,
    output logic             blk_ready,
    output logic             wr_en,
    output logic [PTR_W-1:0] wr_ptr,
    input  logic             req_a,
    input  logic             req_b,
    output logic             shift_a,
    output logic             shift_b,
    output logic [PTR_W-1:0] rd_cnt_a,
    output logic [PTR_W-1:0] rd_cnt_b,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - LANES);
    localparam logic [PTR_W-1:0] LANES_P = PTR_W'(LANES);
    localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);
    localparam logic [PTR_W-1:0] ZERO_P  = '0;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

    state_t           state;
    logic             mode;
    logic             toggle;
    logic [PTR_W-1:0] ptr;
    logic             blk_acc;
    logic             acc_a;
    logic             acc_b;

    // toggle mirrors ~blk_ready in FILL and enforces the one-block-per-two-cycles cadence
    assign blk_acc = (state == FILL) && blk_valid && !toggle;
    assign acc_a   = (state == DRAIN) && req_a && (rd_cnt_a < DEPTH_P);
    assign acc_b   = (state == DRAIN) && mode && req_b && (rd_cnt_b < DEPTH_P);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            mode      <= 1'b0;
            toggle    <= 1'b0;
            ptr       <= ZERO_P;
            blk_ready <= 1'b0;
            wr_en     <= 1'b0;
            wr_ptr    <= ZERO_P;
            shift_a   <= 1'b0;
            shift_b   <= 1'b0;
            rd_cnt_a  <= ZERO_P;
            rd_cnt_b  <= ZERO_P;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            wr_en   <= 1'b0;
            shift_a <= 1'b0;
            shift_b <= 1'b0;
            done    <= 1'b0;
            if (!Enable) begin
                state     <= IDLE;
                ptr       <= ZERO_P;
                toggle    <= 1'b0;
                blk_ready <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            mode      <= mode_par;
                            ptr       <= ZERO_P;
                            toggle    <= 1'b0;
                            rd_cnt_a  <= ZERO_P;
                            rd_cnt_b  <= ZERO_P;
                            blk_ready <= 1'b1;
                            busy      <= 1'b1;
                            state     <= FILL;
                        end
                    end
                    FILL: begin
                        if (blk_acc) begin
                            wr_en     <= 1'b1;
                            wr_ptr    <= ptr;
                            ptr       <= ptr + LANES_P;
                            toggle    <= 1'b1;
                            blk_ready <= 1'b0;
                            if (ptr == LAST_P) begin
                                state <= DRAIN;
                            end
                        end else begin
                            toggle    <= 1'b0;
                            blk_ready <= 1'b1;
                        end
                    end
                    DRAIN: begin
                        shift_a <= acc_a;
                        shift_b <= acc_b;
                        if (acc_a) begin
                            rd_cnt_a <= rd_cnt_a + ONE_P;
                        end
                        if (acc_b) begin
                            rd_cnt_b <= rd_cnt_b + ONE_P;
                        end
                        if ((rd_cnt_a == DEPTH_P) && (!mode || (rd_cnt_b == DEPTH_P))) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef RWAVE_CTRL_ERR_EN
    logic err_evt;

    assign err_evt = ((state == FILL) && (req_a || req_b)) ||
                     ((state == DRAIN) && req_a && (rd_cnt_a == DEPTH_P)) ||
                     ((state == DRAIN) && req_b && (!mode || (rd_cnt_b == DEPTH_P)));

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            err <= 1'b0;
        end else if (Enable) begin
            if ((state == IDLE) && start) begin
                err <= 1'b0;
            end else if (err_evt) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rwave_fifo_ctrl.sv
// Directed bench for rwave_fifo_ctrl: expected write pointers and tap counts queued, popped on wr_en/shift_a.
module tb_rwave_fifo_ctrl;
    localparam int DEPTH = 800;
    localparam int LANES = 8;
    localparam int PTR_W = 10;
`ifdef RWAVE_CTRL_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             Reset, Enable, start, mode_par, blk_valid, req_a, req_b;
    logic             blk_ready, wr_en, shift_a, shift_b, busy, done, err;
    logic [PTR_W-1:0] wr_ptr, rd_cnt_a, rd_cnt_b;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    rwave_fifo_ctrl #(.DEPTH(DEPTH), .LANES(LANES), .PTR_W(PTR_W)) dut (
        .clk(clk), .Reset(Reset), .Enable(Enable), .start(start), .mode_par(mode_par),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .wr_en(wr_en), .wr_ptr(wr_ptr),
        .req_a(req_a), .req_b(req_b), .shift_a(shift_a), .shift_b(shift_b),
        .rd_cnt_a(rd_cnt_a), .rd_cnt_b(rd_cnt_b), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic m);
        start    = 1'b1;
        mode_par = m;
        tick();
        start    = 1'b0;
    endtask

    task automatic run_fill(output int n);
        blk_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 300 && n < DEPTH / LANES; i++) begin
            tick();
            if (wr_en) n++;
        end
        blk_valid = 1'b0;
    endtask

    initial begin
        int n, nb, last, dn, late, hit;
        logic sat_a;
        Reset = 1'b1; Enable = 1'b1; start = 1'b0; mode_par = 1'b0;
        blk_valid = 1'b0; req_a = 1'b0; req_b = 1'b0;
        #1;
        check("rst_out", {blk_ready, wr_en, shift_a, shift_b, busy, done, err}, 0);
        check("rst_cnt", {wr_ptr, rd_cnt_a, rd_cnt_b}, 0);
        tick();
        Reset = 1'b0;
        tick();

        // reset asserted mid-fill while ptr=96 (wr_ptr 88 just written)
        do_start(1'b0);
        blk_valid = 1'b1;
        hit = 0;
        for (int i = 0; i < 100 && hit == 0; i++) begin
            tick();
            if (wr_en && wr_ptr == 88) hit = 1;
        end
        check("midfill_reached", hit, 1);
        Reset = 1'b1;
        #1;
        check("midfill_rst_out", {blk_ready, wr_en, shift_a, shift_b, busy, done, err}, 0);
        check("midfill_rst_ptr", wr_ptr, 0);
        blk_valid = 1'b0;
        tick();
        Reset = 1'b0;
        tick();

        // fill cadence, serial mode
        for (int k = 0; k < DEPTH / LANES; k++) exp_q.push_back(k * LANES);
        do_start(1'b0);
        check("fill_busy", busy, 1);
        check("fill_rdy_idle0", blk_ready, 1);
        tick();
        check("fill_rdy_idle1", blk_ready, 1);
        check("fill_no_wr_idle", wr_en, 0);
        blk_valid = 1'b1;
        n = 0; last = -1; nb = 0;
        for (int i = 0; i < 300 && n < DEPTH / LANES; i++) begin
            tick();
            if (wr_en) begin
                check("fill_wr_ptr", wr_ptr, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdead);
                if (last >= 0 && i - last != 2) nb++;
                last = i;
                n++;
            end
        end
        check("fill_writes", n, DEPTH / LANES);
        check("fill_gap_errs", nb, 0);
        check("fill_q_empty", exp_q.size(), 0);
        check("fill_cycles", last + 1, 2 * (DEPTH / LANES) - 1);
        check("drain_rdy0", blk_ready, 0);
        tick();
        check("drain_rdy0_hold", {blk_ready, wr_en, busy}, 3'b001);

        // serial drain with req_b held: B must stay untouched
        blk_valid = 1'b0;
        for (int k = 1; k <= DEPTH; k++) exp_q.push_back(k);
        req_a = 1'b1; req_b = 1'b1;
        n = 0; nb = 0; dn = 0;
        for (int i = 0; i < 2000 && dn == 0; i++) begin
            tick();
            if (shift_a) begin
                check("ser_cnt_a", rd_cnt_a, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdead);
                n++;
            end
            if (shift_b) nb++;
            if (done) dn++;
        end
        req_a = 1'b0; req_b = 1'b0;
        check("ser_shift_a", n, DEPTH);
        check("ser_shift_b", nb, 0);
        check("ser_done", dn, 1);
        check("ser_cnts", {rd_cnt_a, rd_cnt_b}, {10'(DEPTH), 10'd0});
        tick();
        check("ser_done_pulse", {done, busy}, 0);
        tick();
        check("ser_cnt_hold", rd_cnt_a, DEPTH);

        // parallel drain, req_b every third cycle
        do_start(1'b1);
        run_fill(n);
        check("par_fill", n, DEPTH / LANES);
        req_a = 1'b1;
        n = 0; nb = 0; dn = 0; late = 0; sat_a = 1'b0;
        for (int i = 0; i < 3000 && dn == 0; i++) begin
            req_b = (i % 3 == 0);
            tick();
            if (shift_a) n++;
            if (shift_a && sat_a) late++;
            sat_a = (rd_cnt_a == DEPTH);
            if (shift_b) nb++;
            if (done) begin
                dn++;
                check("par_done_cnt_b", rd_cnt_b, DEPTH);
                check("par_done_cnt_a", rd_cnt_a, DEPTH);
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        check("par_done", dn, 1);
        check("par_shift_a", n, DEPTH);
        check("par_shift_b", nb, DEPTH);
        check("par_late_a", late, 0);
        tick();
        tick();

        // abort via Enable at wr_ptr=400
        do_start(1'b0);
        blk_valid = 1'b1;
        hit = 0;
        for (int i = 0; i < 200 && hit == 0; i++) begin
            tick();
            if (wr_en && wr_ptr == 400) hit = 1;
        end
        check("abort_reached", hit, 1);
        Enable = 1'b0;
        tick();
        Enable = 1'b1;
        blk_valid = 1'b0;
        check("abort_idle", {busy, blk_ready, wr_en, done}, 0);
        dn = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done || busy) dn++;
        end
        check("abort_quiet", dn, 0);
        exp_q.push_back(0); exp_q.push_back(8);
        do_start(1'b0);
        blk_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 20 && n < 2; i++) begin
            tick();
            if (wr_en) begin
                check("refill_ptr", wr_ptr, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdead);
                n++;
            end
        end
        check("refill_writes", n, 2);
        blk_valid = 1'b0;
        Enable = 1'b0;
        tick();
        Enable = 1'b1;
        tick();

        // error flag: req_a in FILL, sticky through DONE, cleared by next start
        do_start(1'b0);
        check("err_start_clr", err, 0);
        req_a = 1'b1;
        tick();
        req_a = 1'b0;
        check("err_fill_req", err, ERR_EN);
        run_fill(n);
        check("err_fill", n, DEPTH / LANES);
        req_a = 1'b1;
        dn = 0;
        for (int i = 0; i < 2000 && dn == 0; i++) begin
            tick();
            if (done) begin
                dn++;
                check("err_at_done", err, ERR_EN);
            end
        end
        req_a = 1'b0;
        check("err_done_seen", dn, 1);
        tick();
        check("err_idle_hold", err, ERR_EN);
        do_start(1'b1);
        check("err_restart_clr", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
